// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue slice.
// Holds the default renamed-op width, tag geometry and the tag readiness
// helper used by every slot.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 32
`endif

package issue_queue_pkg;

  localparam int TAG_W    = 5;
  localparam int NUM_TAGS = 30;

  // Tags at or above NUM_TAGS carry no dependency.
  function automatic logic tag_no_dep(input logic [TAG_W-1:0] tag);
    return (tag >= TAG_W'(NUM_TAGS));
  endfunction

  // Live readiness of one source: no-dependency tags are always ready,
  // otherwise the physical register's done flag decides.
  function automatic logic tag_done(input logic [NUM_TAGS-1:0] flags,
                                    input logic [TAG_W-1:0]    tag);
    logic r;
    if (tag_no_dep(tag)) begin
      r = 1'b1;
    end else begin
      r = flags[tag];
    end
    return r;
  endfunction

endpackage

// File: rtl/issue_queue_slot.sv
// One issue-queue slot: op payload, valid bit and per-source sticky ready bits.
// Ports:
//   clk, clear        - clock and synchronous clear of the valid bit
//   done_flags        - physical-register written flags
//   load_en/instr     - write a new op from dispatch (wins over shift)
//   shift_*           - take over the contents of the next-younger slot
//   valid, instr      - stored state
//   sticky_upd        - sticky bits ORed with this cycle's flags (fed to slot-1)
//   ready             - slot holds an op whose sources are all available now
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 32
`endif

module issue_queue_slot
  import issue_queue_pkg::*;
#(
  parameter int INST_WIDTH = `RENAMED_OP_SZ,
  parameter int SRC_COUNT  = 2
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [NUM_TAGS-1:0]   done_flags,
  input  logic                  load_en,
  input  logic [INST_WIDTH-1:0] load_instr,
  input  logic                  shift_en,
  input  logic                  shift_valid,
  input  logic [INST_WIDTH-1:0] shift_instr,
  input  logic [SRC_COUNT-1:0]  shift_sticky,
  output logic                  valid,
  output logic [INST_WIDTH-1:0] instr,
  output logic [SRC_COUNT-1:0]  sticky_upd,
  output logic                  ready
);

  logic                  valid_r;
  logic [INST_WIDTH-1:0] instr_r;
  logic [SRC_COUNT-1:0]  sticky_r;
  logic [SRC_COUNT-1:0]  live_s;
  logic [SRC_COUNT-1:0]  load_live_s;

  // Per-source live readiness for the stored op and for the op being loaded.
  always_comb begin
    live_s      = '0;
    load_live_s = '0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      live_s[i]      = tag_done(done_flags, instr_r[TAG_W*i +: TAG_W]);
      load_live_s[i] = tag_done(done_flags, load_instr[TAG_W*i +: TAG_W]);
    end
  end

  // A flag seen this cycle counts immediately, so ready uses the updated bits.
  always_comb begin
    sticky_upd = sticky_r | live_s;
    ready      = valid_r & (&sticky_upd);
  end

  // Slot state: clear, then load, then shift-in, otherwise accumulate flags.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_r  <= 1'b0;
      instr_r  <= '0;
      sticky_r <= '0;
    end else if (load_en) begin
      valid_r  <= 1'b1;
      instr_r  <= load_instr;
      sticky_r <= load_live_s;
    end else if (shift_en) begin
      valid_r  <= shift_valid;
      instr_r  <= shift_instr;
      sticky_r <= shift_sticky;
    end else begin
      sticky_r <= sticky_upd;
    end
  end

  assign valid = valid_r;
  assign instr = instr_r;

endmodule

// File: rtl/issue_queue.sv
// Age-ordered, collapsing issue queue for renamed micro-ops.
// Ports:
//   clk, rst, flush   - clock, synchronous reset, synchronous clear
//   done_flags        - bit t set when physical tag t is written
//   instr/input_valid - op offered by dispatch; input_ready when a slot is free
//   instr_out/output_valid/output_ready - op offered to the functional unit
//   count             - occupied slots
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 32
`endif

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int INST_WIDTH = `RENAMED_OP_SZ,
  parameter int DEPTH      = 4,
  parameter int SRC_COUNT  = 2,
  parameter int IN_ORDER   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_TAGS-1:0]        done_flags,
  input  logic [INST_WIDTH-1:0]      instr,
  input  logic                       input_valid,
  input  logic                       output_ready,
  output logic [INST_WIDTH-1:0]      instr_out,
  output logic                       input_ready,
  output logic                       output_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0]      count_r;
  logic                  clear_s;
  logic                  enq_s;
  logic                  deq_s;
  logic [CNT_W-1:0]      wr_idx_s;
  logic                  sel_found_s;
  logic [IDX_W-1:0]      sel_idx_s;

  logic                  slot_valid_s  [DEPTH];
  logic [INST_WIDTH-1:0] slot_instr_s  [DEPTH];
  logic [SRC_COUNT-1:0]  slot_sticky_s [DEPTH];
  logic [DEPTH-1:0]      slot_ready_s;
  logic [DEPTH-1:0]      load_en_s;
  logic [DEPTH-1:0]      shift_en_s;

  assign clear_s     = rst | flush;
  // Depends on registered count only, so a full queue refuses even while issuing.
  assign input_ready = (count_r < CNT_W'(DEPTH));
  assign enq_s       = input_valid & input_ready;
  assign deq_s       = sel_found_s & output_ready;
  // A same-cycle dequeue collapses the queue, so the new op lands one lower.
  assign wr_idx_s    = deq_s ? (count_r - CNT_W'(1)) : count_r;

  // Selection priority encoder.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    if (IN_ORDER != 0) begin
      sel_found_s = slot_ready_s[0];
    end else begin
      // Scan from the youngest down so the oldest ready slot wins.
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (slot_ready_s[j]) begin
          sel_found_s = 1'b1;
          sel_idx_s   = IDX_W'(j);
        end else begin
          sel_found_s = sel_found_s;
        end
      end
    end
  end

  // Issue port; the payload is forced to zero when nothing is selected.
  always_comb begin
    output_valid = sel_found_s;
    if (sel_found_s) begin
      instr_out = slot_instr_s[sel_idx_s];
    end else begin
      instr_out = '0;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CNT_W'(enq_s) - CNT_W'(deq_s);
    end
  end

  assign count = count_r;

  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    logic                  sh_valid_s;
    logic [INST_WIDTH-1:0] sh_instr_s;
    logic [SRC_COUNT-1:0]  sh_sticky_s;

    // The youngest slot shifts in an empty entry.
    if (j == DEPTH - 1) begin : g_top
      assign sh_valid_s  = 1'b0;
      assign sh_instr_s  = '0;
      assign sh_sticky_s = '0;
    end else begin : g_mid
      assign sh_valid_s  = slot_valid_s[j+1];
      assign sh_instr_s  = slot_instr_s[j+1];
      assign sh_sticky_s = slot_sticky_s[j+1];
    end

    assign load_en_s[j]  = enq_s & (wr_idx_s == CNT_W'(j));
    assign shift_en_s[j] = deq_s & (CNT_W'(j) >= CNT_W'(sel_idx_s));

    issue_queue_slot #(
      .INST_WIDTH (INST_WIDTH),
      .SRC_COUNT  (SRC_COUNT)
    ) u_slot (
      .clk          (clk),
      .clear        (clear_s),
      .done_flags   (done_flags),
      .load_en      (load_en_s[j]),
      .load_instr   (instr),
      .shift_en     (shift_en_s[j]),
      .shift_valid  (sh_valid_s),
      .shift_instr  (sh_instr_s),
      .shift_sticky (sh_sticky_s),
      .valid        (slot_valid_s[j]),
      .instr        (slot_instr_s[j]),
      .sticky_upd   (slot_sticky_s[j]),
      .ready        (slot_ready_s[j])
    );
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: one out-of-order and one in-order instance
// driven by the same stimulus, DEPTH=4, SRC_COUNT=2, 32-bit ops.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [29:0] done_flags;
  logic [31:0] instr;
  logic        input_valid;
  logic        output_ready;

  logic [31:0] oo_out, io_out;
  logic        oo_ir, io_ir, oo_ov, io_ov;
  logic [2:0]  oo_cnt, io_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  issue_queue #(.INST_WIDTH(32), .DEPTH(4), .SRC_COUNT(2), .IN_ORDER(0)) u_oo (
    .clk(clk), .rst(rst), .flush(flush), .done_flags(done_flags),
    .instr(instr), .input_valid(input_valid), .output_ready(output_ready),
    .instr_out(oo_out), .input_ready(oo_ir), .output_valid(oo_ov), .count(oo_cnt));

  issue_queue #(.INST_WIDTH(32), .DEPTH(4), .SRC_COUNT(2), .IN_ORDER(1)) u_io (
    .clk(clk), .rst(rst), .flush(flush), .done_flags(done_flags),
    .instr(instr), .input_valid(input_valid), .output_ready(output_ready),
    .instr_out(io_out), .input_ready(io_ir), .output_valid(io_ov), .count(io_cnt));

  function automatic logic [31:0] op(input int id, input int t0, input int t1);
    return {8'(id), 14'd0, 5'(t1), 5'(t0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] v);
    input_valid = 1'b1;
    instr       = v;
    tick();
    input_valid = 1'b0;
    instr       = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; done_flags = 30'd0; instr = 32'd0;
    input_valid = 1'b0; output_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset / idle state.
    chk("rst_oo_ov",  32'(oo_ov),  32'd0);
    chk("rst_oo_out", oo_out,      32'd0);
    chk("rst_oo_ir",  32'(oo_ir),  32'd1);
    chk("rst_oo_cnt", 32'(oo_cnt), 32'd0);
    chk("rst_io_ov",  32'(io_ov),  32'd0);
    chk("rst_io_out", io_out,      32'd0);
    chk("rst_io_ir",  32'(io_ir),  32'd1);
    chk("rst_io_cnt", 32'(io_cnt), 32'd0);

    // Fill with four always-ready ops, then drain in order.
    for (int k = 1; k <= 4; k++) enq(op(k, 31, 31));
    chk("full_oo_cnt", 32'(oo_cnt), 32'd4);
    chk("full_oo_ir",  32'(oo_ir),  32'd0);
    chk("full_io_cnt", 32'(io_cnt), 32'd4);
    chk("full_io_ir",  32'(io_ir),  32'd0);
    output_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("drain_oo_ov",  32'(oo_ov), 32'd1);
      chk("drain_oo_out", oo_out,     op(k, 31, 31));
      chk("drain_io_out", io_out,     op(k, 31, 31));
      tick();
    end
    output_ready = 1'b0;
    chk("drain_oo_cnt", 32'(oo_cnt), 32'd0);
    chk("drain_oo_ov",  32'(oo_ov),  32'd0);
    chk("drain_io_out", io_out,      32'd0);

    // A waits on tag 5, B has no dependency.
    enq(op(10, 5, 31));
    enq(op(11, 31, 31));
    chk("ab_oo_ov",  32'(oo_ov), 32'd1);
    chk("ab_oo_out", oo_out,     op(11, 31, 31));
    chk("ab_io_ov",  32'(io_ov), 32'd0);
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    chk("ab_oo_cnt", 32'(oo_cnt), 32'd1);
    chk("ab_io_cnt", 32'(io_cnt), 32'd2);
    chk("ab_oo_ov2", 32'(oo_ov),  32'd0);
    chk("ab_io_ov2", 32'(io_ov),  32'd0);
    // Same-cycle flag makes A issuable.
    done_flags[5] = 1'b1;
    #1;
    chk("flag_oo_out", oo_out, op(10, 5, 31));
    chk("flag_io_ov",  32'(io_ov), 32'd1);
    chk("flag_io_out", io_out, op(10, 5, 31));
    tick();
    // Flag drops; the sticky bit keeps A ready.
    done_flags = 30'd0;
    #1;
    chk("sticky_oo_out", oo_out, op(10, 5, 31));
    chk("sticky_io_out", io_out, op(10, 5, 31));
    output_ready = 1'b1;
    tick();
    chk("ab_oo_ov3",  32'(oo_ov),  32'd0);
    chk("ab_oo_cnt3", 32'(oo_cnt), 32'd0);
    chk("ab_io_out3", io_out,      op(11, 31, 31));
    tick();
    output_ready = 1'b0;
    chk("ab_io_cnt4", 32'(io_cnt), 32'd0);

    // Enqueue and dequeue on the same edge at count=2.
    enq(op(20, 31, 31));
    enq(op(21, 30, 30));
    input_valid = 1'b1; instr = op(22, 31, 30); output_ready = 1'b1;
    #1;
    chk("ed_oo_out", oo_out, op(20, 31, 31));
    tick();
    input_valid = 1'b0; output_ready = 1'b0;
    chk("ed_oo_cnt", 32'(oo_cnt), 32'd2);
    chk("ed_io_cnt", 32'(io_cnt), 32'd2);
    chk("ed_oo_out2", oo_out, op(21, 30, 30));
    output_ready = 1'b1;
    tick();
    chk("ed_oo_out3", oo_out, op(22, 31, 30));
    chk("ed_io_out3", io_out, op(22, 31, 30));
    chk("ed_oo_cnt3", 32'(oo_cnt), 32'd1);
    tick();
    output_ready = 1'b0;
    chk("ed_oo_cnt4", 32'(oo_cnt), 32'd0);

    // Full queue refuses an op even while dequeuing.
    for (int k = 30; k < 34; k++) enq(op(k, 31, 31));
    input_valid = 1'b1; instr = op(39, 31, 31); output_ready = 1'b1;
    tick();
    input_valid = 1'b0; output_ready = 1'b0;
    chk("fullref_oo_cnt", 32'(oo_cnt), 32'd3);
    chk("fullref_io_cnt", 32'(io_cnt), 32'd3);
    enq(op(41, 31, 31));
    chk("refill_oo_cnt", 32'(oo_cnt), 32'd4);

    // Flush overrides simultaneous enqueue and dequeue.
    flush = 1'b1; input_valid = 1'b1; instr = op(40, 31, 31); output_ready = 1'b1;
    tick();
    flush = 1'b0; input_valid = 1'b0; output_ready = 1'b0;
    chk("flush_oo_cnt", 32'(oo_cnt), 32'd0);
    chk("flush_oo_ov",  32'(oo_ov),  32'd0);
    chk("flush_oo_out", oo_out,      32'd0);
    chk("flush_oo_ir",  32'(oo_ir),  32'd1);
    chk("flush_io_cnt", 32'(io_cnt), 32'd0);
    chk("flush_io_ov",  32'(io_ov),  32'd0);
    tick();
    chk("flush_oo_ov2", 32'(oo_ov), 32'd0);
    chk("flush_io_ov2", 32'(io_ov), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

Multi-entry, parametrised issue queue for renamed micro-ops. Accepts one renamed op per cycle from rename/dispatch, holds up to DEPTH ops, and tracks per-source operand readiness against the physical-register done flags. Each cycle it presents at most one ready op to the execution unit under a selectable issue policy. Sits between dispatch and each functional unit and replaces single-entry, capped issue slots.

## Interface
- INST_WIDTH, default `RENAMED_OP_SZ: width of a renamed op.
- DEPTH, default 4: number of slots, 2..16.
- SRC_COUNT, default 2: source tags per op, 1..3.
- IN_ORDER, default 0: 1 = only the oldest op may issue; 0 = oldest ready op issues.
- clk  in  1: clock; all state changes on its rising edge.
- rst  in  1: synchronous, active-high reset.
- flush  in  1: synchronous clear of all slots (branch recovery).
- done_flags  in  30: bit t high means physical tag t has its result written.
- instr  in  INST_WIDTH: incoming op. Source i tag is in instr[5*i +: 5].
- input_valid  in  1: instr is valid.
- output_ready  in  1: the functional unit accepts instr_out this cycle.
- instr_out  out  INST_WIDTH: selected op; 0 when output_valid is low.
- input_ready  out  1: a slot is free.
- output_valid  out  1: instr_out is ready to issue.
- count  out  $clog2(DEPTH+1): occupied slots.

## Operation
- Slots are age-ordered and collapsing. Slot 0 is the oldest. Valid slots are contiguous from 0.
- Tag rules:
  - A tag value below 30 means a dependency on done_flags[tag].
  - Tag values 30 and 31 mean no dependency and are ready immediately.
- Each slot stores the op plus SRC_COUNT sticky ready bits.
  - On enqueue, each bit is set to the no-dependency condition OR done_flags[tag].
  - Every cycle, each bit is ORed with done_flags[tag].
- Slot ready = slot valid AND, for every source, (sticky bit OR live done_flags[tag]). A flag that rises in cycle t makes the op issuable in cycle t.
- Selection:
  - IN_ORDER=0: the lowest-index ready slot.
  - IN_ORDER=1: slot 0 only, and only if it is ready.
- output_valid = a slot is selected. instr_out = that slot's op.
- Dequeue happens when output_valid AND output_ready. Slots above the removed index shift down one position and keep their sticky bits, including bits updated that same cycle.
- Enqueue happens when input_valid AND input_ready. The new op is written at index count, or count−1 when a dequeue happens in the same cycle.
- input_ready = (count < DEPTH). It is registered-state-only and has no combinational path from output_ready or input_valid. A full queue refuses new ops even in a cycle where it dequeues.
- count next = count + enq − deq.
- flush or rst clears all valid bits and count to 0. Both override any enqueue or dequeue in the same cycle. Slot payloads are don't-care after clear.

## Timing
- Reset values:
  - output_valid 0
  - instr_out 0
  - input_ready 1
  - count 0
- Enqueue to earliest issue is 1 cycle: an op accepted at edge t can appear on output_valid in the cycle after t, if its sources are ready.
- The done_flags to output_valid path is combinational, within the same cycle.
- Issue throughput is 1 op per cycle. Enqueue and dequeue may both happen on the same edge.
- Once output_valid is high with output_ready low, the selected op may change to an older op that becomes ready. No stability is promised, and the consumer must not assume any.
- Back-to-back full operation (enqueue one op and dequeue one op every cycle) is sustained when count < DEPTH at the start.

## Structure
- Shared defines header holds `RENAMED_OP_SZ, TAG_W=5, NUM_TAGS=30, and the no-dependency threshold (tag ≥ NUM_TAGS).
- Sub-module issue_queue_slot holds one op, its valid bit and its sticky ready bits. It exposes:
  - ready
  - a shift-in port from slot+1
  - a load port from instr
- The top level holds:
  - the selection priority encoder
  - the compaction and write-index control
  - the count register

## Test plan
- Reset, then idle: output_valid=0, instr_out=0, input_ready=1, count=0.
- Enqueue 4 ops with tags 31/31 into DEPTH=4: count=4 and input_ready=0. The ops issue in order 0,1,2,3 with output_ready=1, one per cycle.
- IN_ORDER=0:
  - Enqueue A (src tag 5) then B (src tag 31), with done_flags=0. B issues first.
  - Raise done_flags[5] for one cycle. A issues that same cycle, or later via its sticky bit with flags back at 0.
- IN_ORDER=1, same A and B stimulus: nothing issues until done_flags[5] rises. Then A issues, then B.
- Queue at count=2, enqueue and dequeue slot 0 on the same edge: count stays 2, and the new op lands at slot 1 behind the old slot 1.
- With the queue full, assert flush together with input_valid and output_ready: next cycle count=0, output_valid=0, and the offered op is not stored.
